mnist_cmd_sequencer: RTL and testbench
======================================

Name: mnist_cmd_sequencer

Overview:
Command-level controller for the MNIST accelerator inside the system wrapper. It parses host command bytes delivered by the UART receiver, streams a 28x28 image into the accelerator's image BRAM, and starts the CNN. It then waits for completion and returns a one-byte response to the UART transmitter. It is the only block that drives the accelerator's start and image-write interfaces.

Parameters:
IMG_BYTES, 784, pixel bytes per image load
ADDR_W, 10, image BRAM address width
TIMEOUT_CYCLES, 10_000_000, idle cycles allowed between load bytes and while awaiting acc_done (100 ms at 100 MHz); benches override with a small value

Ports:
clk_100MHz  in  1  system clock
reset_rtl_0  in  1  synchronous, active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe per received byte; no backpressure
tx_data  out  8  response byte
tx_valid  out  1  response valid
tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready
bram_addr  out  ADDR_W  image BRAM write address
bram_wdata  out  8  image BRAM write data
bram_we  out  1  image BRAM write enable
acc_start  out  1  one-cycle inference start pulse
acc_done  in  1  one-cycle completion pulse
acc_result  in  4  predicted class, valid in the acc_done cycle
img_loaded  out  1  a complete image is resident in the BRAM
busy  out  1  high in every state except IDLE
rx_overrun  out  1  sticky: a byte was dropped; cleared only by reset

Behaviour:
- Reset (reset_rtl_0==0 at a clk_100MHz edge) returns the block to IDLE and clears all outputs: tx_valid, bram_we, acc_start, img_loaded, busy, rx_overrun = 0; tx_data, bram_addr, bram_wdata = 0. Reset mid-load or mid-inference aborts the operation immediately with no response.
- Constants: CMD_LOAD=0x4C, CMD_RUN=0x52, CMD_PING=0x50, RSP_ACK=0x06, RSP_NAK=0x15; a class response is 0x30+acc_result.
- FSM states: IDLE, LOAD, START, WAIT_DONE, SEND.
- IDLE, on rx_valid:
  - LOAD byte: img_loaded<=0, byte counter<=0, go to LOAD.
  - RUN byte with img_loaded=1: go to START.
  - RUN byte with img_loaded=0: queue NAK, go to SEND.
  - PING byte: queue ACK, go to SEND.
  - Any other byte: queue NAK, go to SEND.
- LOAD:
  - A byte accepted at edge N produces bram_we=1 for exactly one cycle after edge N+1, with bram_addr=counter and bram_wdata=byte; the counter then increments.
  - The write of address IMG_BYTES-1 sets img_loaded=1, queues ACK, and goes to SEND.
  - Bytes interpreted as pixels are never decoded as commands.
- START: acc_start=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: on acc_done, sample acc_result.
  - Value <=9: queue 0x30+value.
  - Value >9: queue NAK.
  - Go to SEND. img_loaded stays 1, so repeated RUN commands reuse the image.
- SEND:
  - tx_valid=1 with tx_data stable until the tx_valid&tx_ready cycle, then go to IDLE.
  - tx_valid rises the cycle after the transition into SEND.
- Timeout:
  - One counter clears on entry to LOAD or WAIT_DONE and on every accepted byte in LOAD, and increments otherwise in those states.
  - Reaching TIMEOUT_CYCLES-1 queues NAK and goes to SEND.
  - A LOAD timeout leaves img_loaded=0.
  - acc_done in the same cycle as the timeout: acc_done wins.
- Dropped bytes: rx_valid in START, WAIT_DONE or SEND drops the byte and sets rx_overrun.
- acc_done outside WAIT_DONE is ignored.
- busy = (state != IDLE), registered.

Decomposition:
- Package mnist_ctrl_pkg holds the command/response byte constants, the IMG_BYTES default, and the state enum type seq_state_t.
- One natural sub-module, mnist_timeout_ctr, provides the clear/enable/expire counter parameterised by TIMEOUT_CYCLES.
- The FSM and the BRAM write pipeline stay in mnist_cmd_sequencer.

Test Plan:
- Reset, then PING (0x50) -> exactly one byte 0x06 on tx; busy returns to 0; a tx_ready stall of 5 cycles holds tx_data=0x06 stable.
- LOAD followed by bytes 0..783 (byte i = i mod 256) -> 784 single-cycle bram_we pulses, addr 0..783, wdata = addr mod 256, each one cycle after its rx_valid; then ACK; img_loaded=1.
- After the load, RUN; acc model returns done with result 7 after 50 cycles -> one acc_start pulse, then tx byte 0x37; a second RUN -> another start and a second response.
- RUN with no image loaded -> 0x15 and no acc_start; unknown byte 0x00 -> 0x15.
- TIMEOUT_CYCLES=100: LOAD plus 10 bytes, then silence -> NAK at the 100th idle cycle and img_loaded=0. With the acc model never asserting done -> NAK after 100 cycles.
- Assert reset mid-load at byte 400 -> all outputs 0 the next cycle; a following PING is answered with 0x06. A byte arriving during WAIT_DONE sets rx_overrun=1.

Source files
------------

// File: rtl/mnist_ctrl_pkg.sv
// mnist_ctrl_pkg: shared constants and types for the MNIST command sequencer.
//   - host command bytes and response bytes
//   - default image size in pixel bytes
//   - sequencer state type
//   - helper mapping a predicted class to its response byte
package mnist_ctrl_pkg;

  localparam logic [7:0] CMD_LOAD       = 8'h4C;
  localparam logic [7:0] CMD_RUN        = 8'h52;
  localparam logic [7:0] CMD_PING       = 8'h50;
  localparam logic [7:0] RSP_ACK        = 8'h06;
  localparam logic [7:0] RSP_NAK        = 8'h15;
  localparam logic [7:0] RSP_CLASS_BASE = 8'h30;

  localparam int unsigned IMG_BYTES_DEFAULT = 784;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_DONE,
    S_SEND
  } seq_state_t;

  // Classes 0..9 map to ASCII digits; anything larger is an invalid result.
  function automatic logic [7:0] class_rsp(input logic [3:0] cls);
    return (cls <= 4'd9) ? (RSP_CLASS_BASE + {4'h0, cls}) : RSP_NAK;
  endfunction

endpackage

// File: rtl/mnist_cmd_sequencer_if.sv
// mnist_cmd_sequencer_if: byte streams and accelerator hooks around the sequencer.
//   rx_data/rx_valid     : received host byte, one-cycle strobe, no backpressure
//   tx_data/tx_valid/tx_ready : response byte handshake toward the UART transmitter
//   bram_addr/bram_wdata/bram_we : image BRAM write port
//   acc_start/acc_done/acc_result : accelerator start pulse and completion
// master = the sequencer, slave = the surrounding system.
interface mnist_cmd_sequencer_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] bram_addr;
  logic [7:0]        bram_wdata;
  logic              bram_we;
  logic              acc_start;
  logic              acc_done;
  logic [3:0]        acc_result;

  modport master (
    input  rx_data, rx_valid, tx_ready, acc_done, acc_result,
    output tx_data, tx_valid, bram_addr, bram_wdata, bram_we, acc_start
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, acc_done, acc_result,
    input  tx_data, tx_valid, bram_addr, bram_wdata, bram_we, acc_start
  );
endinterface

// File: rtl/mnist_timeout_ctr.sv
// mnist_timeout_ctr: idle-cycle counter with synchronous clear.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force count to zero (has priority over en)
//   en         : count while high; saturates at TIMEOUT_CYCLES-1
//   expired    : en is high and the count has reached TIMEOUT_CYCLES-1
module mnist_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == LAST);
endmodule

// File: rtl/mnist_cmd_sequencer.sv
// mnist_cmd_sequencer: host command controller for the MNIST accelerator.
//   clk_100MHz  : system clock
//   reset_rtl_0 : synchronous active-low reset, aborts any operation silently
//   bus         : rx bytes in, tx response out, image BRAM writes, acc start/done
//   img_loaded  : a complete image is resident in the BRAM
//   busy        : sequencer is not idle
//   rx_overrun  : sticky, a byte arrived while no byte could be accepted
// Commands: LOAD streams IMG_BYTES pixels to the BRAM then ACKs, RUN starts
// inference and returns the class digit, PING ACKs, anything else NAKs.
module mnist_cmd_sequencer
  import mnist_ctrl_pkg::*;
#(
  parameter int unsigned IMG_BYTES      = IMG_BYTES_DEFAULT,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                   clk_100MHz,
  input  logic                   reset_rtl_0,
  mnist_cmd_sequencer_if.master  bus,
  output logic                   img_loaded,
  output logic                   busy,
  output logic                   rx_overrun
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] byte_cnt;
  logic              pend_we;
  logic [7:0]        pend_data;
  logic              wr_now, last_wr;
  logic              rsp_load;
  logic [7:0]        rsp_byte;
  logic              to_en, to_clr, to_expired;

  // Pixels pass through one capture stage before the BRAM write stage.
  assign wr_now  = pend_we && (state == S_LOAD);
  assign last_wr = wr_now && (byte_cnt == LAST_ADDR);

  // Outside LOAD/WAIT_DONE the counter is held clear, so it starts from zero
  // on entry to either state.
  assign to_en  = (state == S_LOAD) || (state == S_WAIT_DONE);
  assign to_clr = !to_en || ((state == S_LOAD) && bus.rx_valid);

  mnist_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk_100MHz),
    .rst_n   (reset_rtl_0),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  always_comb begin
    state_nxt = state;
    rsp_load  = 1'b0;
    rsp_byte  = RSP_NAK;
    case (state)
      S_IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            CMD_LOAD: state_nxt = S_LOAD;
            CMD_RUN: begin
              if (img_loaded) begin
                state_nxt = S_START;
              end else begin
                rsp_load  = 1'b1;
                state_nxt = S_SEND;
              end
            end
            CMD_PING: begin
              rsp_load  = 1'b1;
              rsp_byte  = RSP_ACK;
              state_nxt = S_SEND;
            end
            default: begin
              rsp_load  = 1'b1;
              state_nxt = S_SEND;
            end
          endcase
        end
      end
      S_LOAD: begin
        if (last_wr) begin
          rsp_load  = 1'b1;
          rsp_byte  = RSP_ACK;
          state_nxt = S_SEND;
        end else if (to_expired && !bus.rx_valid && !pend_we) begin
          rsp_load  = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_START: state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (bus.acc_done) begin
          rsp_load  = 1'b1;
          rsp_byte  = class_rsp(bus.acc_result);
          state_nxt = S_SEND;
        end else if (to_expired) begin
          rsp_load  = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.tx_valid && bus.tx_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_rtl_0) begin
      state          <= S_IDLE;
      byte_cnt       <= '0;
      pend_we        <= 1'b0;
      pend_data      <= '0;
      bus.tx_data    <= '0;
      bus.tx_valid   <= 1'b0;
      bus.bram_addr  <= '0;
      bus.bram_wdata <= '0;
      bus.bram_we    <= 1'b0;
      bus.acc_start  <= 1'b0;
      img_loaded     <= 1'b0;
      busy           <= 1'b0;
      rx_overrun     <= 1'b0;
    end else begin
      state         <= state_nxt;
      busy          <= (state_nxt != S_IDLE);
      bus.acc_start <= (state_nxt == S_START);
      bus.tx_valid  <= (state == S_SEND) && !(bus.tx_valid && bus.tx_ready);
      if (rsp_load) bus.tx_data <= rsp_byte;

      pend_we <= (state == S_LOAD) && bus.rx_valid;
      if (bus.rx_valid) pend_data <= bus.rx_data;

      bus.bram_we <= wr_now;
      if (wr_now) begin
        bus.bram_addr  <= byte_cnt;
        bus.bram_wdata <= pend_data;
        byte_cnt       <= byte_cnt + 1'b1;
      end

      if ((state == S_IDLE) && (state_nxt == S_LOAD)) begin
        img_loaded <= 1'b0;
        byte_cnt   <= '0;
      end
      if (last_wr) img_loaded <= 1'b1;

      if (bus.rx_valid &&
          ((state == S_START) || (state == S_WAIT_DONE) || (state == S_SEND)))
        rx_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mnist_cmd_sequencer.sv
// Scoreboard bench for mnist_cmd_sequencer: stimulus pushes expected tx bytes
// and BRAM writes into queues; a negedge monitor pops and compares them.
module tb_mnist_cmd_sequencer;
  localparam int unsigned TO     = 100;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned IMG    = 784;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic img_loaded, busy, rx_overrun;

  mnist_cmd_sequencer_if #(.ADDR_W(ADDR_W)) bus();

  mnist_cmd_sequencer #(
    .IMG_BYTES(IMG),
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_100MHz (clk),
    .reset_rtl_0(rst_n),
    .bus        (bus),
    .img_loaded (img_loaded),
    .busy       (busy),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0]  addr;
    logic [7:0]  data;
    int unsigned cyc;
  } wr_t;

  logic [7:0]  exp_tx[$];
  wr_t         exp_wr[$];
  wr_t         w;
  int unsigned n_wr = 0;
  int unsigned n_start = 0;
  int unsigned last_rx = 0;
  bit          acc_respond = 1'b0;
  logic [3:0]  acc_res = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got 0x%0h expected no byte", bus.tx_data);
        end else begin
          check("tx_byte", bus.tx_data, exp_tx.pop_front());
        end
      end
      if (bus.bram_we) begin
        n_wr++;
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got addr 0x%0h expected no write", bus.bram_addr);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", bus.bram_addr, w.addr);
          check("wr_data", bus.bram_wdata, w.data);
          check("wr_cycle", cyc, w.cyc);
        end
      end
      if (bus.acc_start) n_start++;
    end
  end

  // Accelerator model: done with acc_res 50 cycles after start when enabled
  initial begin
    bus.acc_done   = 1'b0;
    bus.acc_result = 4'h0;
    forever begin
      @(negedge clk);
      if (bus.acc_start && acc_respond) begin
        repeat (50) @(posedge clk);
        #1 bus.acc_done = 1'b1;
        bus.acc_result = acc_res;
        @(posedge clk);
        #1 bus.acc_done = 1'b0;
        bus.acc_result = 4'h0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit pix, input logic [9:0] addr);
    wr_t e;
    @(posedge clk);
    #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    last_rx      = cyc;
    if (pix) begin
      e.addr = addr;
      e.data = b;
      e.cyc  = cyc + 2;
      exp_wr.push_back(e);
    end
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && exp_tx.size() == 0 && exp_wr.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle: got busy=%0d pending_tx=%0d expected idle with none pending",
               name, busy, exp_tx.size());
    end
  endtask

  task automatic wait_tx_valid(input string name, output int unsigned at);
    bit ok = 1'b0;
    at = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.tx_valid) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_txvalid: got no tx_valid expected tx_valid within 300 cycles", name);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx_valid"},   bus.tx_valid, 0);
    check({name, "_tx_data"},    bus.tx_data, 0);
    check({name, "_bram_we"},    bus.bram_we, 0);
    check({name, "_bram_addr"},  bus.bram_addr, 0);
    check({name, "_bram_wdata"}, bus.bram_wdata, 0);
    check({name, "_acc_start"},  bus.acc_start, 0);
    check({name, "_img_loaded"}, img_loaded, 0);
    check({name, "_busy"},       busy, 0);
    check({name, "_rx_overrun"}, rx_overrun, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s0, w0, t0, t;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // PING with a 5-cycle tx stall
    bus.tx_ready = 1'b0;
    exp_tx.push_back(8'h06);
    send_byte(8'h50, 1'b0, '0);
    wait_tx_valid("ping", t);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ping_hold_data", bus.tx_data, 8'h06);
      check("ping_hold_valid", bus.tx_valid, 1);
    end
    @(posedge clk);
    #1 bus.tx_ready = 1'b1;
    wait_idle("ping");
    check("ping_busy", busy, 0);

    // RUN with no image, unknown byte
    s0 = n_start;
    exp_tx.push_back(8'h15);
    send_byte(8'h52, 1'b0, '0);
    wait_idle("run_noimg");
    check("run_noimg_starts", n_start - s0, 0);
    exp_tx.push_back(8'h15);
    send_byte(8'h00, 1'b0, '0);
    wait_idle("unknown");

    // Full image load
    w0 = n_wr;
    exp_tx.push_back(8'h06);
    send_byte(8'h4C, 1'b0, '0);
    for (int i = 0; i < int'(IMG); i++) send_byte(8'(i), 1'b1, 10'(i));
    wait_idle("load");
    check("load_writes", n_wr - w0, IMG);
    check("load_img_loaded", img_loaded, 1);

    // RUN with results 7, 9, 10
    acc_respond = 1'b1;
    acc_res = 4'd7;
    s0 = n_start;
    exp_tx.push_back(8'h37);
    send_byte(8'h52, 1'b0, '0);
    wait_idle("run7");
    check("run7_starts", n_start - s0, 1);
    acc_res = 4'd9;
    exp_tx.push_back(8'h39);
    send_byte(8'h52, 1'b0, '0);
    wait_idle("run9");
    check("run9_starts", n_start - s0, 2);
    acc_res = 4'd10;
    exp_tx.push_back(8'h15);
    send_byte(8'h52, 1'b0, '0);
    wait_idle("run10");
    check("run10_starts", n_start - s0, 3);
    check("run_img_kept", img_loaded, 1);

    // Accelerator never completes; a byte during WAIT_DONE overruns
    acc_respond = 1'b0;
    s0 = n_start;
    exp_tx.push_back(8'h15);
    send_byte(8'h52, 1'b0, '0);
    t0 = last_rx;
    repeat (10) @(posedge clk);
    send_byte(8'h50, 1'b0, '0);
    wait_tx_valid("acc_to", t);
    check("acc_to_cycle", t, t0 + 103);
    wait_idle("acc_to");
    check("acc_to_starts", n_start - s0, 1);
    check("acc_to_overrun", rx_overrun, 1);
    check("acc_to_img_kept", img_loaded, 1);

    // LOAD timeout after 10 pixels
    w0 = n_wr;
    exp_tx.push_back(8'h15);
    send_byte(8'h4C, 1'b0, '0);
    for (int i = 0; i < 10; i++) send_byte(8'(i + 8'hA0), 1'b1, 10'(i));
    t0 = last_rx;
    wait_tx_valid("load_to", t);
    check("load_to_cycle", t, t0 + 102);
    wait_idle("load_to");
    check("load_to_writes", n_wr - w0, 10);
    check("load_to_img_loaded", img_loaded, 0);

    // Reset mid-load at byte 400
    send_byte(8'h4C, 1'b0, '0);
    for (int i = 0; i <= 400; i++) send_byte(8'(i), 1'b1, 10'(i));
    repeat (3) @(posedge clk);
    check("midload_busy", busy, 1);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midload_reset");
    exp_wr.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_tx.push_back(8'h06);
    send_byte(8'h50, 1'b0, '0);
    wait_idle("post_reset_ping");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
